mem_req_ctrl: RTL and testbench

Sequences data-memory transactions for the MEM stage. It accepts one load or store at a time from the pipeline and drives the SRAM-like data bus (req/addr_ok/data_ok). It returns read data to the load-extraction logic and discards in-flight responses when the pipeline is flushed by an exception. Only one transaction is ever outstanding.

---
 rtl/mem_req_ctrl_pkg.sv | 31 +++
 rtl/mem_resp_buf.sv | 60 ++++++
 rtl/mem_req_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl_pkg
// Shared types and constants for the MEM-stage data-memory request controller.
//   virt_t / uint32_t     : 32-bit address and data types
//   mem_req_ctrl_state_t  : controller FSM states
//   MEM_SIZE_*            : encodings of the req_size / data_sram_size field
//   load_capture()        : response data seen by the pipeline (0 for stores)
// -----------------------------------------------------------------------------
package mem_req_ctrl_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    RESP    = 3'd3,
    DISCARD = 3'd4
  } mem_req_ctrl_state_t;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  // Stores return no data; whatever the bus drives on rdata is ignored.
  function automatic uint32_t load_capture(input logic wr, input uint32_t rdata);
    return wr ? '0 : rdata;
  endfunction

endpackage

// File: rtl/mem_resp_buf.sv
// -----------------------------------------------------------------------------
// mem_resp_buf
// Response holding register for mem_req_ctrl: a 32-bit data register with its
// valid bit. It is loaded when a transaction completes and cleared when the
// consumer takes the response or the pipeline flushes it.
//
// Optional feature macro: MEM_REQ_CTRL_RESP_BYPASS_EN
//   When defined, a completing bus response (live) is forwarded to resp_valid /
//   resp_rdata combinationally in the same cycle, ahead of the register.
//
// Ports
//   clk, resetn   : clock, asynchronous active-low reset
//   load          : capture load_data and set valid
//   load_data     : data to capture (already zeroed for stores)
//   clear         : drop the held response
//   live          : (bypass build only) completing response this cycle
//   resp_valid    : response available to the consumer
//   resp_rdata    : response data
// -----------------------------------------------------------------------------
module mem_resp_buf
  import mem_req_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic    load,
  input  uint32_t load_data,
  input  logic    clear,
`ifdef MEM_REQ_CTRL_RESP_BYPASS_EN
  input  logic    live,
`endif
  output logic    resp_valid,
  output uint32_t resp_rdata
);

  logic    valid_q;
  uint32_t data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

`ifdef MEM_REQ_CTRL_RESP_BYPASS_EN
  // live never coincides with valid_q: completion only happens in REQ/WAIT,
  // while the register is only valid in RESP.
  assign resp_valid = valid_q | live;
  assign resp_rdata = live ? load_data : data_q;
`else
  assign resp_valid = valid_q;
  assign resp_rdata = data_q;
`endif

endmodule

// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
// MEM-stage data-memory transaction sequencer. Accepts one load/store at a
// time from the pipeline, drives the SRAM-like data bus (req / addr_ok /
// data_ok), returns load data, and swallows in-flight responses when the
// pipeline is flushed. Only one transaction is ever outstanding.
//
// Optional feature macro: MEM_REQ_CTRL_RESP_BYPASS_EN
//   Forwards a completing response to resp_valid/resp_rdata in the same cycle
//   as data_ok; with resp_ready high the FSM returns straight to IDLE.
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// clk edge where both sides are high; a source holds its valid and payload
// stable until that edge. Pipeline side: req_valid/req_ready (req_ready only
// in IDLE), resp_valid/resp_ready. Bus side: data_sram_req/data_sram_addr_ok
// for the request, data_sram_data_ok for the response (no back-pressure).
// req_cancel overrides everything and is not a handshake.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   req_*                : pipeline request (valid/ready, wr, size, addr,
//                          wstrb, wdata) and req_cancel flush
//   resp_*               : response to the load-extraction logic
//   data_sram_*          : data bus request fields and response inputs
//   busy                 : FSM not in IDLE
//   dbg_state            : current FSM state
// -----------------------------------------------------------------------------
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  virt_t               req_addr,
  input  logic [3:0]          req_wstrb,
  input  uint32_t             req_wdata,
  input  logic                req_cancel,
  output logic                resp_valid,
  output uint32_t             resp_rdata,
  input  logic                resp_ready,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [1:0]          data_sram_size,
  output virt_t               data_sram_addr,
  output logic [3:0]          data_sram_wstrb,
  output uint32_t             data_sram_wdata,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  input  uint32_t             data_sram_rdata,
  output logic                busy,
  output mem_req_ctrl_state_t dbg_state
);

  mem_req_ctrl_state_t state;
  logic                drop;       // sticky: flushed while the request was pending

  logic    drop_now;               // flush seen now or earlier in REQ
  logic    complete;               // a response is delivered to the pipeline
  logic    direct;                 // delivered and consumed in the same cycle
  logic    buf_load;
  logic    buf_clear;
  uint32_t complete_data;

  assign drop_now = drop | req_cancel;

  // A transaction completes with a response only when data_ok arrives and no
  // flush is pending: in REQ that needs addr_ok in the same cycle.
  assign complete = data_sram_data_ok &
                    (((state == REQ)  & data_sram_addr_ok & ~drop_now) |
                     ((state == WAIT) & ~req_cancel));

  assign complete_data = load_capture(data_sram_wr, data_sram_rdata);

`ifdef MEM_REQ_CTRL_RESP_BYPASS_EN
  assign direct   = complete & resp_ready;
  assign buf_load = complete & ~resp_ready;
`else
  assign direct   = 1'b0;
  assign buf_load = complete;
`endif

  // Leaving RESP either via the handshake or a flush empties the buffer.
  assign buf_clear = (state == RESP) & (req_cancel | resp_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      drop            <= 1'b0;
      data_sram_wr    <= 1'b0;
      data_sram_size  <= '0;
      data_sram_addr  <= '0;
      data_sram_wstrb <= '0;
      data_sram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A flush in the same cycle as the op means the op never existed.
          if (req_valid & ~req_cancel) begin
            data_sram_wr    <= req_wr;
            data_sram_size  <= req_size;
            data_sram_addr  <= req_addr;
            data_sram_wstrb <= req_wstrb;
            data_sram_wdata <= req_wdata;
            drop            <= 1'b0;
            state           <= REQ;
          end
        end
        REQ: begin
          // The request cannot be withdrawn once raised; a flush only marks
          // the eventual response for disposal.
          if (data_sram_addr_ok) begin
            drop <= 1'b0;
            if (data_sram_data_ok) begin
              state <= (drop_now | direct) ? IDLE : RESP;
            end else begin
              state <= drop_now ? DISCARD : WAIT;
            end
          end else begin
            drop <= drop_now;
          end
        end
        WAIT: begin
          if (data_sram_data_ok) begin
            state <= (req_cancel | direct) ? IDLE : RESP;
          end else if (req_cancel) begin
            state <= DISCARD;
          end
        end
        RESP: begin
          if (req_cancel | resp_ready) begin
            state <= IDLE;
          end
        end
        DISCARD: begin
          if (data_sram_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign data_sram_req = (state == REQ);
  assign dbg_state     = state;

  mem_resp_buf u_resp_buf (
    .clk        (clk),
    .resetn     (resetn),
    .load       (buf_load),
    .load_data  (complete_data),
    .clear      (buf_clear),
`ifdef MEM_REQ_CTRL_RESP_BYPASS_EN
    .live       (complete),
`endif
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
  );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_req_ctrl
// Directed bench for mem_req_ctrl. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge. A response monitor pops the
// expected-data queue on every resp_valid/resp_ready handshake, so spurious or
// duplicate responses are reported as well as wrong data.
// -----------------------------------------------------------------------------
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

`ifdef MEM_REQ_CTRL_RESP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                resetn;
  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [1:0]          req_size;
  logic [31:0]         req_addr;
  logic [3:0]          req_wstrb;
  logic [31:0]         req_wdata;
  logic                req_cancel;
  logic                resp_valid;
  logic [31:0]         resp_rdata;
  logic                resp_ready;
  logic                data_sram_req;
  logic                data_sram_wr;
  logic [1:0]          data_sram_size;
  logic [31:0]         data_sram_addr;
  logic [3:0]          data_sram_wstrb;
  logic [31:0]         data_sram_wdata;
  logic                data_sram_addr_ok;
  logic                data_sram_data_ok;
  logic [31:0]         data_sram_rdata;
  logic                busy;
  mem_req_ctrl_state_t dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  mem_req_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_wr            (req_wr),
    .req_size          (req_size),
    .req_addr          (req_addr),
    .req_wstrb         (req_wstrb),
    .req_wdata         (req_wdata),
    .req_cancel        (req_cancel),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_ready        (resp_ready),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .busy              (busy),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [3:0] wstrb, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_wr    = wr;
    req_size  = size;
    req_addr  = addr;
    req_wstrb = wstrb;
    req_wdata = wdata;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rdata);
    data_sram_addr_ok = aok;
    data_sram_data_ok = dok;
    data_sram_rdata   = rdata;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (resetn && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) check("unexpected_resp", resp_rdata, 32'hXXXX_XXXX);
      else                   check("resp_data", resp_rdata, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_size   = 2'd0;
    req_addr   = '0;
    req_wstrb  = '0;
    req_wdata  = '0;
    req_cancel = 1'b0;
    resp_ready = 1'b1;
    bus(1'b0, 1'b0, 32'h0);

    // Reset state
    sample();
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_sram_req", data_sram_req, 0);
    check("rst_sram_addr", data_sram_addr, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    tick();
    resetn = 1'b1;

    // Load, ideal bus
    issue(1'b0, MEM_SIZE_WORD, 32'h0000_1000, 4'h0, 32'h0);
    sample();
    check("t1_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    bus(1'b1, 1'b1, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    sample();
    check("t1_sram_req", data_sram_req, 1);
    check("t1_sram_size", data_sram_size, 2);
    check("t1_sram_wr", data_sram_wr, 0);
    check("t1_sram_addr", data_sram_addr, 32'h0000_1000);
    check("t1_resp_early", resp_valid, BYP);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    sample();
    check("t1_req_low", data_sram_req, 0);
    check("t1_resp_valid", resp_valid, !BYP);
    check("t1_req_ready", req_ready, BYP);
    tick();
    sample();
    check("t1_idle", dbg_state, IDLE);

    // Store with stalls; pipeline fields change under the request
    issue(1'b1, MEM_SIZE_BYTE, 32'h0000_2003, 4'h8, 32'h1100_0000);
    tick();
    issue(1'b0, MEM_SIZE_WORD, 32'hFFFF_FFFC, 4'hF, 32'hA5A5_A5A5);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_sram_addr_ok = (i == 3);
      sample();
      check("t2_req", data_sram_req, 1);
      check("t2_addr", data_sram_addr, 32'h0000_2003);
      check("t2_wstrb", data_sram_wstrb, 4'h8);
      check("t2_wdata", data_sram_wdata, 32'h1100_0000);
      check("t2_wr", data_sram_wr, 1);
      check("t2_size", data_sram_size, MEM_SIZE_BYTE);
      tick();
    end
    bus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sample();
      check("t2_wait_req", data_sram_req, 0);
      check("t2_wait_busy", busy, 1);
      check("t2_wait_resp", resp_valid, 0);
      tick();
    end
    bus(1'b0, 1'b1, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    sample();
    check("t2_resp_early", resp_valid, BYP);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    sample();
    check("t2_resp_valid", resp_valid, !BYP);
    tick();
    sample();
    check("t2_idle", dbg_state, IDLE);

    // Cancel in WAIT
    issue(1'b0, MEM_SIZE_WORD, 32'h0000_3000, 4'h0, 32'h0);
    tick();
    req_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
    sample();
    check("t3_req", data_sram_req, 1);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    req_cancel = 1'b1;
    sample();
    check("t3_wait", dbg_state, WAIT);
    tick();
    req_cancel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("t3_discard", dbg_state, DISCARD);
      check("t3_busy", busy, 1);
      check("t3_no_resp", resp_valid, 0);
      tick();
    end
    bus(1'b0, 1'b1, 32'h1234_5678);
    sample();
    check("t3_busy_dok", busy, 1);
    check("t3_no_resp_dok", resp_valid, 0);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    issue(1'b0, MEM_SIZE_WORD, 32'h0000_4000, 4'h0, 32'h0);
    sample();
    check("t3_next_busy", busy, 0);
    check("t3_next_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    bus(1'b1, 1'b1, 32'hCAFE_F00D);
    exp_q.push_back(32'hCAFE_F00D);
    sample();
    check("t3_next_addr", data_sram_addr, 32'h0000_4000);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    tick();
    sample();
    check("t3_idle", dbg_state, IDLE);

    // Cancel in REQ while addr_ok is low
    issue(1'b0, MEM_SIZE_HALF, 32'h0000_5000, 4'h0, 32'h0);
    tick();
    req_valid  = 1'b0;
    req_cancel = 1'b1;
    sample();
    check("t4_req_cancel", data_sram_req, 1);
    tick();
    req_cancel = 1'b0;
    sample();
    check("t4_req_held", data_sram_req, 1);
    check("t4_state_req", dbg_state, REQ);
    tick();
    bus(1'b1, 1'b0, 32'h0);
    sample();
    check("t4_req_aok", data_sram_req, 1);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    sample();
    check("t4_discard", dbg_state, DISCARD);
    check("t4_req_low", data_sram_req, 0);
    tick();
    bus(1'b0, 1'b1, 32'hBAD0_BAD0);
    sample();
    check("t4_no_resp", resp_valid, 0);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    sample();
    check("t4_idle", dbg_state, IDLE);
    check("t4_no_resp_after", resp_valid, 0);

    // Stray data_ok in IDLE, and valid+cancel in IDLE, are both ignored
    bus(1'b0, 1'b1, 32'h0BAD_F00D);
    issue(1'b0, MEM_SIZE_WORD, 32'h0000_5500, 4'h0, 32'h0);
    req_cancel = 1'b1;
    tick();
    bus(1'b0, 1'b0, 32'h0);
    req_valid  = 1'b0;
    req_cancel = 1'b0;
    sample();
    check("t4_stray_idle", dbg_state, IDLE);
    check("t4_stray_resp", resp_valid, 0);
    check("t4_cancel_noreq", data_sram_req, 0);

    // Back-pressure in RESP
    resp_ready = 1'b0;
    issue(1'b0, MEM_SIZE_WORD, 32'h0000_6000, 4'h0, 32'h0);
    tick();
    req_valid = 1'b0;
    bus(1'b1, 1'b1, 32'h0A0B_0C0D);
    exp_q.push_back(32'h0A0B_0C0D);
    sample();
    check("t5_resp_early", resp_valid, BYP);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    issue(1'b0, MEM_SIZE_WORD, 32'h0000_7000, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t5_hold_valid", resp_valid, 1);
      check("t5_hold_data", resp_rdata, 32'h0A0B_0C0D);
      check("t5_req_ready", req_ready, 0);
      check("t5_state", dbg_state, RESP);
      tick();
    end
    resp_ready = 1'b1;
    sample();
    check("t5_hs_valid", resp_valid, 1);
    tick();
    sample();
    check("t5_after_hs_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    bus(1'b1, 1'b1, 32'h7777_7777);
    exp_q.push_back(32'h7777_7777);
    sample();
    check("t5_next_addr", data_sram_addr, 32'h0000_7000);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    tick();
    sample();
    check("t5_idle", dbg_state, IDLE);

    // Reset asserted in WAIT
    issue(1'b1, MEM_SIZE_WORD, 32'h0000_8000, 4'hF, 32'h0000_0055);
    tick();
    req_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    sample();
    check("t6_wait", dbg_state, WAIT);
    #1 resetn = 1'b0;
    #1;
    check("t6_state", dbg_state, IDLE);
    check("t6_req_ready", req_ready, 1);
    check("t6_busy", busy, 0);
    check("t6_sram_req", data_sram_req, 0);
    check("t6_sram_addr", data_sram_addr, 0);
    check("t6_sram_wdata", data_sram_wdata, 0);
    check("t6_sram_wstrb", data_sram_wstrb, 0);
    check("t6_sram_wr", data_sram_wr, 0);
    check("t6_resp_valid", resp_valid, 0);
    check("t6_resp_rdata", resp_rdata, 0);
    tick();
    resetn = 1'b1;
    sample();
    check("t6_idle", dbg_state, IDLE);

`ifdef MEM_REQ_CTRL_RESP_BYPASS_EN
    // Back-to-back loads at two cycles each with the bypass
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, MEM_SIZE_WORD, 32'h0000_9000 + 32'(k * 4), 4'h0, 32'h0);
      sample();
      check("byp_accept", req_ready, 1);
      tick();
      req_valid = 1'b0;
      bus(1'b1, 1'b1, 32'h9000_0000 + 32'(k));
      exp_q.push_back(32'h9000_0000 + 32'(k));
      sample();
      check("byp_same_cycle", resp_valid, 1);
      tick();
      bus(1'b0, 1'b0, 32'h0);
    end
`endif

    tick();
    tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
